// File: rtl/qar_spi_flash_reader.sv
// SPI-flash READ (0x03) sequencer driving the qar_spi register port: cmd, 3 addr bytes, len dummy bytes.
// Latency: accept -> first status poll 4 cycles; done pulses the cycle after the last byte is taken.
// Backpressure: one data byte in flight; out_ready low parks the FSM in OUT_WAIT with the bus idle.
module qar_spi_flash_reader #(
    parameter int          LEN_W   = 16,
    parameter logic [31:0] CLKDIV  = 32'd1,
    parameter logic [3:0]  CS_MASK = 4'b0001,
    parameter int          TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             done,
    output logic             err,
    output logic             m_bus_write,
    output logic             m_bus_read,
    output logic [5:0]       m_addr_word,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    localparam int IDX_W = LEN_W + 1;
    localparam int PC_W  = $clog2(TIMEOUT + 1);

    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_STAT   = 6'd1;
    localparam logic [5:0] W_CLKDIV = 6'd2;
    localparam logic [5:0] W_TXDATA = 6'd3;
    localparam logic [5:0] W_RXDATA = 6'd4;
    localparam logic [5:0] W_CS     = 6'd5;
    localparam logic [5:0] W_FLAGS  = 6'd7;

    typedef enum logic [3:0] {
        IDLE, CFG_DIV, CFG_CS, CFG_CTRL, POLL_TX, WR_TX,
        POLL_RX, RD_RX, OUT_WAIT, ERR_CLR, FINISH
    } state_t;

    state_t             state, state_nxt;
    logic [23:0]        addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   byte_idx;
    logic [PC_W-1:0]    poll_cnt;

    logic [IDX_W-1:0]   end_idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               idx_in_hdr;
    logic               last_data;
    logic               poll_last;
    logic               st_fault, st_tx_rdy, st_rx_rdy;
    logic [7:0]         tx_byte;

    logic               bus_wr_nxt, bus_rd_nxt;
    logic [5:0]         bus_addr_nxt;
    logic [31:0]        bus_wdata_nxt;

    logic               rdata_unused;
    assign rdata_unused = &{1'b0, m_rdata[31:8]};

    assign end_idx    = {1'b0, len_q} + IDX_W'(4);
    assign idx_inc    = byte_idx + IDX_W'(1);
    assign idx_in_hdr = byte_idx < IDX_W'(4);
    assign last_data  = idx_inc == end_idx;
    assign poll_last  = poll_cnt == PC_W'(TIMEOUT - 1);
    assign st_fault   = m_rdata[3];
    assign st_tx_rdy  = m_rdata[0];
    assign st_rx_rdy  = m_rdata[1];

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            IDX_W'(0): tx_byte = 8'h03;
            IDX_W'(1): tx_byte = addr_q[23:16];
            IDX_W'(2): tx_byte = addr_q[15:8];
            IDX_W'(3): tx_byte = addr_q[7:0];
            default:   tx_byte = 8'h00;
        endcase
    end

    // Status word is only meaningful in POLL_*, where the read strobe is always up.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = (req_len == '0) ? FINISH : CFG_DIV;
            CFG_DIV:  state_nxt = CFG_CS;
            CFG_CS:   state_nxt = CFG_CTRL;
            CFG_CTRL: state_nxt = POLL_TX;
            POLL_TX: begin
                if (st_fault)       state_nxt = ERR_CLR;
                else if (st_tx_rdy) state_nxt = WR_TX;
                else if (poll_last) state_nxt = ERR_CLR;
            end
            WR_TX:    state_nxt = POLL_RX;
            POLL_RX: begin
                if (st_fault)       state_nxt = ERR_CLR;
                else if (st_rx_rdy) state_nxt = RD_RX;
                else if (poll_last) state_nxt = ERR_CLR;
            end
            RD_RX: begin
                if (!idx_in_hdr)          state_nxt = OUT_WAIT;
                else if (idx_inc == end_idx) state_nxt = FINISH;
                else                      state_nxt = POLL_TX;
            end
            OUT_WAIT: if (out_ready) state_nxt = (byte_idx == end_idx) ? FINISH : POLL_TX;
            ERR_CLR:  state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus strobes are registered, so they are decoded from the state being entered.
    always_comb begin
        bus_wr_nxt    = 1'b0;
        bus_rd_nxt    = 1'b0;
        bus_addr_nxt  = 6'd0;
        bus_wdata_nxt = 32'd0;
        case (state_nxt)
            CFG_DIV: begin
                bus_wr_nxt    = 1'b1;
                bus_addr_nxt  = W_CLKDIV;
                bus_wdata_nxt = CLKDIV;
            end
            CFG_CS: begin
                bus_wr_nxt    = 1'b1;
                bus_addr_nxt  = W_CS;
                bus_wdata_nxt = {28'd0, CS_MASK};
            end
            CFG_CTRL: begin
                bus_wr_nxt    = 1'b1;
                bus_addr_nxt  = W_CTRL;
                bus_wdata_nxt = 32'h1;
            end
            POLL_TX, POLL_RX: begin
                bus_rd_nxt    = 1'b1;
                bus_addr_nxt  = W_STAT;
            end
            WR_TX: begin
                bus_wr_nxt    = 1'b1;
                bus_addr_nxt  = W_TXDATA;
                bus_wdata_nxt = {24'd0, tx_byte};
            end
            RD_RX: begin
                bus_rd_nxt    = 1'b1;
                bus_addr_nxt  = W_RXDATA;
            end
            ERR_CLR: begin
                bus_wr_nxt    = 1'b1;
                bus_addr_nxt  = W_FLAGS;
                bus_wdata_nxt = 32'h4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            byte_idx    <= '0;
            poll_cnt    <= '0;
            req_ready   <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            m_bus_write <= 1'b0;
            m_bus_read  <= 1'b0;
            m_addr_word <= 6'd0;
            m_wdata     <= 32'd0;
        end else begin
            state       <= state_nxt;
            req_ready   <= state_nxt == IDLE;
            done        <= state_nxt == FINISH;
            err         <= (state_nxt == FINISH) && (state == ERR_CLR);
            m_bus_write <= bus_wr_nxt;
            m_bus_read  <= bus_rd_nxt;
            m_addr_word <= bus_addr_nxt;
            m_wdata     <= bus_wdata_nxt;

            if (state_nxt != state)
                poll_cnt <= '0;
            else if (state == POLL_TX || state == POLL_RX)
                poll_cnt <= poll_cnt + PC_W'(1);

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        len_q    <= req_len;
                        byte_idx <= '0;
                    end
                end
                RD_RX: begin
                    byte_idx <= idx_inc;
                    if (!idx_in_hdr) begin
                        out_data  <= m_rdata[7:0];
                        out_valid <= 1'b1;
                        out_last  <= last_data;
                    end
                end
                OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                ERR_CLR: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qar_spi_flash_reader.sv
// Directed bench: behavioural qar_spi register model with a READ-responding flash (mem[a] = a[7:0]^A5).
module tb_qar_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;
    logic        err;
    logic        m_bus_write;
    logic        m_bus_read;
    logic [5:0]  m_addr_word;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    qar_spi_flash_reader #(
        .LEN_W(16), .CLKDIV(32'd1), .CS_MASK(4'b0001), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err),
        .m_bus_write(m_bus_write), .m_bus_read(m_bus_read), .m_addr_word(m_addr_word),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // qar_spi model state
    logic        stall = 1'b0;
    logic        fault_arm = 1'b0;
    logic        fault_reg = 1'b0;
    logic        rx_full = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  pend = 8'h00;
    int          busy_cnt = 0;
    int          xfer = 0;
    logic [23:0] faddr = 24'h0;
    logic [23:0] cur_a;
    logic [7:0]  resp;
    logic [31:0] wr0 = 0, wr2 = 0, wr5 = 0, wr7 = 0;
    logic [7:0]  mosi_q[$];

    assign cur_a = faddr + 24'(xfer) - 24'd4;
    assign resp  = (xfer < 4) ? 8'hFF : (cur_a[7:0] ^ 8'hA5);

    always_comb begin
        m_rdata = 32'd0;
        if (m_bus_read && m_addr_word == 6'd1) begin
            m_rdata[0] = (busy_cnt == 0) && !rx_full;
            m_rdata[1] = rx_full;
            m_rdata[3] = fault_reg;
        end else if (m_bus_read && m_addr_word == 6'd4) begin
            m_rdata[7:0] = rx_byte;
        end
    end

    always @(posedge clk) begin
        if (busy_cnt != 0 && !stall) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                rx_full <= 1'b1;
                rx_byte <= pend;
            end
        end
        if (m_bus_read && m_addr_word == 6'd4) rx_full <= 1'b0;
        if (m_bus_write) begin
            case (m_addr_word)
                6'd0: begin
                    wr0 <= m_wdata; busy_cnt <= 0; rx_full <= 1'b0; xfer <= 0;
                    fault_reg <= fault_arm;
                end
                6'd2: wr2 <= m_wdata;
                6'd5: wr5 <= m_wdata;
                6'd3: begin
                    mosi_q.push_back(m_wdata[7:0]);
                    busy_cnt <= 3;
                    pend <= resp;
                    xfer <= xfer + 1;
                    if (xfer >= 1 && xfer <= 3) faddr <= {faddr[15:0], m_wdata[7:0]};
                end
                6'd7: begin
                    wr7 <= m_wdata;
                    if (m_wdata[2]) fault_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Monitor
    int cyc = 0, acc_cyc = 0, lat = -1;
    logic lat_arm = 1'b0;
    int n_wr = 0, n_rd = 0, n_stat = 0, n_both = 0, n_wd_bad = 0, n_wr7 = 0;
    int n_done = 0, n_err = 0, n_done_err = 0, n_err_bad = 0, n_ov = 0;
    logic [7:0] out_q[$];
    logic       last_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_bus_write) n_wr <= n_wr + 1;
        if (m_bus_read) n_rd <= n_rd + 1;
        if (m_bus_read && m_addr_word == 6'd1) n_stat <= n_stat + 1;
        if (m_bus_write && m_addr_word == 6'd7) n_wr7 <= n_wr7 + 1;
        if (m_bus_write && m_bus_read) n_both <= n_both + 1;
        if (!m_bus_write && m_wdata != 32'd0) n_wd_bad <= n_wd_bad + 1;
        if (done) n_done <= n_done + 1;
        if (err) n_err <= n_err + 1;
        if (done && err) n_done_err <= n_done_err + 1;
        if (err && !done) n_err_bad <= n_err_bad + 1;
        if (out_valid) n_ov <= n_ov + 1;
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (req_valid && req_ready) begin
            acc_cyc <= cyc;
            lat_arm <= 1'b1;
        end else if (lat_arm && m_bus_read && m_addr_word == 6'd1) begin
            lat <= cyc - acc_cyc;
            lat_arm <= 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] q[$]);
        logic [63:0] r = 64'd0;
        foreach (q[i]) r = {r[55:0], q[i]};
        return r;
    endfunction

    function automatic logic [63:0] packb(input logic q[$]);
        logic [63:0] r = 64'd0;
        foreach (q[i]) r = {r[62:0], q[i]};
        return r;
    endfunction

    task automatic send_req(input logic [23:0] a, input logic [15:0] l);
        int i = 0;
        @(negedge clk);
        req_addr = a; req_len = l; req_valid = 1'b1;
        while (!req_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int i = 0;
        while (n_done == base && i < 600) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check(tag, 64'(n_done - base), 64'd1);
    endtask

    task automatic clear_logs();
        out_q.delete();
        last_q.delete();
        mosi_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done, b_err, b_de, b_wr, b_rd, b_stat, b_wr7, b_ov, i, bad;
        logic [7:0] held;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = 24'h0; req_len = 16'h0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done_err", 64'({done, err, out_last}), 64'd0);
        check("rst_bus_strobes", 64'({m_bus_write, m_bus_read}), 64'd0);
        check("rst_bus_addr_data", 64'({m_addr_word, m_wdata}), 64'd0);
        rst_n = 1'b1;

        // Plain 2-byte read
        clear_logs();
        b_done = n_done; b_err = n_err;
        send_req(24'h012345, 16'd2);
        wait_done(b_done, "t1_done");
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_clkdiv", 64'(wr2), 64'd1);
        check("t1_cs", 64'(wr5), 64'd1);
        check("t1_ctrl", 64'(wr0), 64'd1);
        check("t1_mosi_cnt", 64'(mosi_q.size()), 64'd6);
        check("t1_mosi", pack8(mosi_q), 64'h0000_0301_2345_0000);
        check("t1_out", pack8(out_q), 64'hE0E3);
        check("t1_last", packb(last_q), 64'b01);
        check("t1_err", 64'(n_err - b_err), 64'd0);
        check("t1_idle_ready", 64'(req_ready), 64'd1);

        // Consumer stalls on the first data byte
        clear_logs();
        out_ready = 1'b0;
        b_done = n_done;
        send_req(24'h012345, 16'd2);
        i = 0;
        while (!out_valid && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t2_valid_seen", 64'(out_valid), 64'd1);
        held = out_data;
        check("t2_byte1", 64'(held), 64'hE0);
        b_wr = n_wr;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === held && out_last === 1'b0)) bad++;
        end
        check("t2_stable", 64'(bad), 64'd0);
        check("t2_no_write", 64'(n_wr - b_wr), 64'd0);
        out_ready = 1'b1;
        wait_done(b_done, "t2_done");
        check("t2_out", pack8(out_q), 64'hE0E3);
        check("t2_mosi", pack8(mosi_q), 64'h0000_0301_2345_0000);

        // Zero-length request
        b_done = n_done; b_err = n_err; b_wr = n_wr; b_rd = n_rd;
        send_req(24'h000010, 16'd0);
        check("t3_done_now", 64'(done), 64'd1);
        check("t3_err_now", 64'(err), 64'd0);
        @(negedge clk);
        check("t3_done_pulse", 64'({done, req_ready}), 64'b01);
        check("t3_no_bus", 64'((n_wr - b_wr) + (n_rd - b_rd)), 64'd0);
        check("t3_done_cnt", 64'(n_done - b_done), 64'd1);

        // Fault seen on the first status poll
        clear_logs();
        fault_arm = 1'b1;
        b_done = n_done; b_err = n_err; b_de = n_done_err; b_wr7 = n_wr7; b_ov = n_ov; b_stat = n_stat;
        send_req(24'h000100, 16'd4);
        wait_done(b_done, "t4_done");
        fault_arm = 1'b0;
        check("t4_err", 64'(n_err - b_err), 64'd1);
        check("t4_done_err_same", 64'(n_done_err - b_de), 64'd1);
        check("t4_wr7_cnt", 64'(n_wr7 - b_wr7), 64'd1);
        check("t4_wr7_data", 64'(wr7), 64'h4);
        check("t4_no_out", 64'(n_ov - b_ov), 64'd0);
        check("t4_polls", 64'(n_stat - b_stat), 64'd1);
        check("t4_no_tx", 64'(mosi_q.size()), 64'd0);

        // RX never becomes ready: 1 TX poll + 16 RX polls, then error
        clear_logs();
        stall = 1'b1;
        b_done = n_done; b_err = n_err; b_stat = n_stat; b_wr7 = n_wr7;
        send_req(24'h000200, 16'd4);
        wait_done(b_done, "t5_done");
        stall = 1'b0;
        check("t5_polls", 64'(n_stat - b_stat), 64'd17);
        check("t5_err", 64'(n_err - b_err), 64'd1);
        check("t5_wr7", 64'(n_wr7 - b_wr7), 64'd1);
        check("t5_ready_after", 64'(req_ready), 64'd1);

        // Reset in the middle of the data phase, then a clean request
        clear_logs();
        b_done = n_done;
        send_req(24'h000300, 16'd4);
        i = 0;
        while (out_q.size() < 1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t6_in_data_phase", 64'(out_q.size() >= 1), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 64'(req_ready), 64'd1);
        check("t6_rst_outs", 64'({out_valid, out_last, done, err}), 64'd0);
        check("t6_rst_bus", 64'({m_bus_write, m_bus_read, m_wdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_done", 64'(n_done - b_done), 64'd0);
        clear_logs();
        b_done = n_done; b_err = n_err;
        send_req(24'h00FFFE, 16'd3);
        wait_done(b_done, "t6_done");
        check("t6_mosi", pack8(mosi_q), 64'h0003_00FF_FE00_0000);
        check("t6_out", pack8(out_q), 64'h5B5AA5);
        check("t6_last", packb(last_q), 64'b001);
        check("t6_err", 64'(n_err - b_err), 64'd0);

        check("bus_exclusive", 64'(n_both), 64'd0);
        check("wdata_zero_idle", 64'(n_wd_bad), 64'd0);
        check("err_only_with_done", 64'(n_err_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
